serial_subtractor: RTL and testbench
====================================

Name: serial_subtractor

Overview:
- Bit-serial N-bit subtractor; computes diff = A - B - bin using a single full-subtractor cell, one bit per clock, LSB first.
- Area-cheap counterpart to the parallel ripple-carry adder datapath; used where subtract latency of N cycles is acceptable.
- Valid/ready handshake on both operand input and result output.

Parameters:
N, 8, operand/result width in bits; legal range 2..64.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operands a, b, bin valid
in_ready  output  1  block can accept operands
a  input  N  minuend
b  input  N  subtrahend
bin  input  1  borrow-in
out_valid  output  1  diff/bout valid
out_ready  input  1  consumer accepts result
diff  output  N  (a - b - bin) mod 2^N
bout  output  1  borrow-out; 1 when a < b + bin (unsigned)

Behaviour:
- One clock, clk; reset asynchronous active-low on rst_n.
- Reset values: state=IDLE, in_ready=1, out_valid=0, diff=0, bout=0, internal shift registers/counter=0.
- FSM states:
  - IDLE: in_ready=1. On in_valid&&in_ready edge: latch a, b into shift regs, borrow reg <= bin, count <= 0, go RUN.
  - RUN: in_ready=0. Each cycle the cell computes d = a_sr[0]^b_sr[0]^borrow and bnext = (~a_sr[0]&b_sr[0]) | (~(a_sr[0]^b_sr[0])&borrow). d shifts into diff MSB, diff shifts right, a_sr/b_sr shift right, borrow <= bnext, count++. When count==N-1 at the edge, go DONE.
  - DONE: out_valid=1; diff/bout stable. On out_valid&&out_ready edge, go IDLE. The same-cycle new accept is not allowed; in_ready rises the cycle after the result handshake.
- Latency: out_valid rises exactly N clock edges after the accept edge. Throughput is one result per N+2 cycles minimum.
- Arithmetic:
  - diff is N bits, wrap-around modulo 2^N.
  - bout = final borrow.
  - Example boundaries: a=0, b=0, bin=1 -> diff=all ones, bout=1. a=b, bin=0 -> diff=0, bout=0.
- Backpressure: out_ready=0 in DONE holds the result indefinitely; a, b, in_valid are ignored outside IDLE.
- in_valid asserted in RUN/DONE has no effect; the operands are not captured.
- Reset mid-operation (any state): return immediately to reset values; the partial result is discarded and out_valid is never asserted for it.
- Counter width: $clog2(N).

Optional Feature:
- Macro: SERIAL_SUB_OVF_EN.
- Defined:
  - Adds output port ovf (1 bit): signed two's-complement overflow, computed as (a[N-1]^b[N-1]) & (a[N-1]^diff[N-1]) using the latched operand MSBs.
  - Valid with out_valid; reset 0.
- Undefined: the port does not exist and there is no overflow logic.

Decomposition:
- Shared package sub_pkg:
  - Typedef state_t (IDLE=2'd0, RUN=2'd1, DONE=2'd2).
  - Constant SUB_N_MAX=64.
- One sub-module, full_subtractor (inputs a, b, bin; outputs d, bout; purely combinational), instantiated once in the serial datapath.

Test Plan:
1. N=8: a=8'h5A, b=8'h3C, bin=0, out_ready=1 -> out_valid high exactly 8 edges after accept; diff=8'h1E, bout=0.
2. N=8: a=8'h00, b=8'h01, bin=0 -> diff=8'hFF, bout=1. Then a=8'h00, b=8'h00, bin=1 -> diff=8'hFF, bout=1.
3. Backpressure: a=8'h10, b=8'h01, out_ready held 0 for 5 cycles after out_valid -> diff=8'h0F stable, in_ready=0 throughout. After out_ready=1, in_ready=1 on the next cycle.
4. Reset mid-RUN: assert rst_n=0 at count=3 -> out_valid, diff, bout=0 immediately; in_ready=1 after release. A new op a=8'h80, b=8'h7F -> diff=8'h01, bout=0.
5. in_valid pulsed during RUN with a=8'hFF -> ignored; result matches the originally accepted operands. Back-to-back ops keep in_valid high continuously -> each result is correct, with a new accept every N+2 cycles.
6. SERIAL_SUB_OVF_EN defined: a=8'h80, b=8'h01 -> diff=8'h7F, ovf=1. With a=8'h05, b=8'h03 -> ovf=0.

Source files
------------

// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor.
//   state_t   : controller states (IDLE, RUN, DONE)
//   SUB_N_MAX : widest supported operand width
package sub_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int unsigned SUB_N_MAX = 64;

endpackage

// File: rtl/full_subtractor.sv
// Single-bit full subtractor cell: d = a - b - bin (one bit), purely combinational.
//   a, b : operand bits
//   bin  : borrow in
//   d    : difference bit
//   bout : borrow out
module full_subtractor (
   input  logic a,
   input  logic b,
   input  logic bin,
   output logic d,
   output logic bout
);

   always_comb begin
      d    = a ^ b ^ bin;
      bout = (~a & b) | (~(a ^ b) & bin);
   end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial N-bit subtractor: diff = (a - b - bin) mod 2^N, one bit per clock, LSB first,
// using a single full_subtractor cell. Result appears N clock edges after the operand accept.
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid / in_ready : operand handshake (a, b, bin)
//   out_valid/out_ready : result handshake (diff, bout)
//   diff, bout          : difference and final borrow
//   ovf                 : signed overflow, present only when SERIAL_SUB_OVF_EN is defined
import sub_pkg::*;

module serial_subtractor #(
   parameter int unsigned N = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         bin,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] diff,
   output logic         bout
`ifdef SERIAL_SUB_OVF_EN
  ,output logic         ovf
`endif
);

   localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   state_t        state, next_state;
   logic [N-1:0]  a_sr, b_sr, diff_sr;
   logic          borrow;
   logic [CW-1:0] count;
   logic          cell_d, cell_bout;

   full_subtractor u_cell (
      .a    (a_sr[0]),
      .b    (b_sr[0]),
      .bin  (borrow),
      .d    (cell_d),
      .bout (cell_bout)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= next_state;
   end

   always_comb begin
      next_state = state;
      in_ready   = 1'b0;
      out_valid  = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) next_state = RUN;
         end
         RUN: begin
            if (count == LAST) next_state = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   // Difference bits enter at the MSB and move right, so after N shifts bit 0 holds the LSB.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_sr    <= '0;
         b_sr    <= '0;
         diff_sr <= '0;
         borrow  <= 1'b0;
         count   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  a_sr   <= a;
                  b_sr   <= b;
                  borrow <= bin;
                  count  <= '0;
               end
            end
            RUN: begin
               a_sr    <= a_sr >> 1;
               b_sr    <= b_sr >> 1;
               diff_sr <= {cell_d, diff_sr[N-1:1]};
               borrow  <= cell_bout;
               count   <= count + 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign diff = diff_sr;
   assign bout = borrow;

`ifdef SERIAL_SUB_OVF_EN
   // Operand sign bits are shifted out during RUN, so they are captured separately at accept.
   logic a_msb, b_msb;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_msb <= 1'b0;
         b_msb <= 1'b0;
      end else if (state == IDLE && in_valid) begin
         a_msb <= a[N-1];
         b_msb <= b[N-1];
      end
   end

   assign ovf = out_valid & (a_msb ^ b_msb) & (a_msb ^ diff_sr[N-1]);
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (N=8): directed cases plus randomized operations
// compared against an arithmetic reference model. Checks ovf when SERIAL_SUB_OVF_EN is defined.
module tb_serial_subtractor;

   localparam int unsigned N = 8;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [N-1:0] a = '0;
   logic [N-1:0] b = '0;
   logic         bin = 1'b0;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [N-1:0] diff;
   logic         bout;
`ifdef SERIAL_SUB_OVF_EN
   logic         ovf;
`endif

   int checks = 0;
   int errors = 0;

   serial_subtractor #(.N(N)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .bin       (bin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .diff      (diff),
      .bout      (bout)
`ifdef SERIAL_SUB_OVF_EN
     ,.ovf       (ovf)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: plain integer arithmetic on the operands.
   function automatic logic [N:0] ref_sub(input logic [N-1:0] x, input logic [N-1:0] y,
                                          input logic bi);
      int signed r;
      r = int'(x) - int'(y) - int'(bi);
      ref_sub[N-1:0] = r[N-1:0];
      ref_sub[N]     = (r < 0);
   endfunction

   function automatic logic ref_ovf(input logic [N-1:0] x, input logic [N-1:0] y,
                                    input logic [N-1:0] d);
      logic xn, yn, dn;
      xn = $signed(x) < 0;
      yn = $signed(y) < 0;
      dn = $signed(d) < 0;
      return (xn != yn) && (dn != xn);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Full operation: accept, latency count, optional in_valid pulse during RUN,
   // backpressure hold, result handshake.
   task automatic run_op(input string tag, input logic [N-1:0] x, input logic [N-1:0] y,
                         input logic bi, input int hold, input bit pulse_junk);
      logic [N:0]   exp;
      logic [N-1:0] held;
      int           cyc;
      exp = ref_sub(x, y, bi);
      check({tag, "_in_ready_idle"}, in_ready, 1'b1);
      a = x; b = y; bin = bi; in_valid = 1'b1; out_ready = (hold == 0);
      tick();
      in_valid = 1'b0;
      a = $urandom; b = $urandom; bin = $urandom;
      cyc = 0;
      while (out_valid !== 1'b1 && cyc < 4 * N) begin
         if (pulse_junk && cyc == 2) begin
            in_valid = 1'b1; a = '1; b = $urandom;
         end else begin
            in_valid = 1'b0;
         end
         check({tag, "_in_ready_busy"}, in_ready, 1'b0);
         tick();
         cyc++;
      end
      in_valid = 1'b0;
      check({tag, "_latency"}, cyc, N);
      check({tag, "_diff"}, diff, exp[N-1:0]);
      check({tag, "_bout"}, bout, exp[N]);
`ifdef SERIAL_SUB_OVF_EN
      check({tag, "_ovf"}, ovf, ref_ovf(x, y, exp[N-1:0]));
`endif
      held = diff;
      for (int i = 0; i < hold; i++) begin
         if (i == 1) in_valid = 1'b1;
         tick();
         check({tag, "_hold_valid"}, out_valid, 1'b1);
         check({tag, "_hold_diff"}, diff, held);
         check({tag, "_hold_in_ready"}, in_ready, 1'b0);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      tick();
      check({tag, "_released_valid"}, out_valid, 1'b0);
      check({tag, "_released_in_ready"}, in_ready, 1'b1);
      out_ready = 1'b0;
   endtask

   initial begin
      logic [N-1:0] qa[$];
      logic [N-1:0] qb[$];
      logic         qbi[$];
      logic [N:0]   exp;
      int           cyc;
      bit           seen;

      // Reset state
      #2;
      check("rst_in_ready", in_ready, 1'b1);
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_diff", diff, '0);
      check("rst_bout", bout, 1'b0);
`ifdef SERIAL_SUB_OVF_EN
      check("rst_ovf", ovf, 1'b0);
`endif
      tick();
      rst_n = 1'b1;
      tick();

      // Directed cases
      run_op("t1", 8'h5A, 8'h3C, 1'b0, 0, 1'b0);
      run_op("t2a", 8'h00, 8'h01, 1'b0, 0, 1'b0);
      run_op("t2b", 8'h00, 8'h00, 1'b1, 0, 1'b0);
      run_op("eq", 8'hA7, 8'hA7, 1'b0, 0, 1'b0);
      run_op("t3", 8'h10, 8'h01, 1'b0, 5, 1'b0);
      run_op("t5_pulse", 8'h33, 8'h11, 1'b1, 0, 1'b1);
      run_op("t6a", 8'h80, 8'h01, 1'b0, 0, 1'b0);
      run_op("t6b", 8'h05, 8'h03, 1'b0, 0, 1'b0);

      // Reset mid-RUN at count == 3
      a = 8'hC3; b = 8'h5A; bin = 1'b1; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      repeat (3) tick();
      rst_n = 1'b0;
      #1;
      check("t4_rst_valid", out_valid, 1'b0);
      check("t4_rst_diff", diff, '0);
      check("t4_rst_bout", bout, 1'b0);
      tick();
      rst_n = 1'b1;
      tick();
      check("t4_in_ready", in_ready, 1'b1);
      cyc = 0;
      while (cyc < 2 * N) begin
         check("t4_no_stale_valid", out_valid, 1'b0);
         tick();
         cyc++;
      end
      run_op("t4_new", 8'h80, 8'h7F, 1'b0, 0, 1'b0);

      // Back-to-back with in_valid held high; operands change right after each accept
      for (int i = 0; i < 5; i++) begin
         qa.push_back($urandom); qb.push_back($urandom); qbi.push_back($urandom);
      end
      out_ready = 1'b1;
      a = qa[0]; b = qb[0]; bin = qbi[0]; in_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         exp = ref_sub(qa[i], qb[i], qbi[i]);
         check("b2b_in_ready", in_ready, 1'b1);
         tick();
         a = qa[i+1]; b = qb[i+1]; bin = qbi[i+1];
         cyc = 0;
         seen = 0;
         while (in_ready !== 1'b1 && cyc < 4 * N) begin
            tick();
            cyc++;
            if (out_valid === 1'b1 && !seen) begin
               seen = 1;
               check("b2b_diff", diff, exp[N-1:0]);
               check("b2b_bout", bout, exp[N]);
            end
         end
         check("b2b_seen", seen, 1'b1);
         check("b2b_period", cyc + 1, N + 2);
      end
      in_valid = 1'b0;
      out_ready = 1'b0;
      tick();
      tick();

      // Randomized operations with random backpressure
      for (int i = 0; i < 25; i++) begin
         run_op("rnd", N'($urandom), N'($urandom), 1'($urandom), int'($urandom_range(0, 3)),
                bit'($urandom_range(0, 1)));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule
